// File: rtl/lsu_mem_master.sv
// Load/store unit master: one RV64 load/store per request against a single-ported 64-bit data memory.
// Optional build macro LSU_MISALIGN_CHECK_EN turns misaligned accesses into faults instead of aligning them.
module lsu_mem_master #(
    parameter int MEM_WORDS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] mem_A,
    output logic [63:0] mem_WD,
    output logic        mem_WE,
    input  logic [63:0] mem_ReadData
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t      state_q;
    logic        we_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [2:0]  funct3_q;
    logic [63:0] merge_buf_q;
    logic [63:0] resp_rdata_q;
    logic        resp_valid_q;
    logic        resp_err_q;

    logic        fault_d;
    logic        is_sd_d;
    logic [63:0] load_data_d;
    logic [63:0] merge_d;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    return 64'h0000_0000_0000_00FF;
            2'd1:    return 64'h0000_0000_0000_FFFF;
            2'd2:    return 64'h0000_0000_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] align_addr(input logic [63:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return a;
            2'd1:    return {a[63:1], 1'b0};
            2'd2:    return {a[63:2], 2'b00};
            default: return {a[63:3], 3'b000};
        endcase
    endfunction

    function automatic logic misaligned(input logic [63:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return a[0];
            2'd2:    return |a[1:0];
            default: return |a[2:0];
        endcase
    endfunction

    function automatic logic [63:0] load_extend(input logic [63:0] word, input logic [2:0] lane,
                                                input logic [2:0] f3);
        logic [63:0] sh;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  return {{56{sh[7]}}, sh[7:0]};
            3'b001:  return {{48{sh[15]}}, sh[15:0]};
            3'b010:  return {{32{sh[31]}}, sh[31:0]};
            3'b011:  return sh;
            3'b100:  return {56'd0, sh[7:0]};
            3'b101:  return {48'd0, sh[15:0]};
            3'b110:  return {32'd0, sh[31:0]};
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] word, input logic [63:0] wd,
                                                input logic [2:0] lane, input logic [1:0] sz);
        logic [63:0] lane_mask;
        lane_mask = size_mask(sz) << {lane, 3'b000};
        return (word & ~lane_mask) | ((wd & size_mask(sz)) << {lane, 3'b000});
    endfunction

    // Request capture: data fields only, qualified by the accept handshake
    always_ff @(posedge clk) begin
        if (req_valid && req_ready) begin
            we_q     <= req_we;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
`ifdef LSU_MISALIGN_CHECK_EN
            addr_q   <= req_addr;
`else
            addr_q   <= align_addr(req_addr, req_funct3[1:0]);
`endif
        end
    end

    always_comb begin
        fault_d = (addr_q[63:3] >= 61'(MEM_WORDS))
                | (!we_q && (funct3_q == 3'b111))
                | (we_q && funct3_q[2]);
`ifdef LSU_MISALIGN_CHECK_EN
        fault_d = fault_d | misaligned(addr_q, funct3_q[1:0]);
`endif
        is_sd_d     = (funct3_q == 3'b011);
        load_data_d = load_extend(mem_ReadData, addr_q[2:0], funct3_q);
        merge_d     = store_merge(mem_ReadData, wdata_q, addr_q[2:0], funct3_q[1:0]);
    end

    // Memory port is a pure decode of state so reset silences it without waiting for an edge
    always_comb begin
        mem_A  = '0;
        mem_WD = '0;
        mem_WE = 1'b0;
        case (state_q)
            ACCESS: begin
                mem_A = {addr_q[63:3], 3'b000};
                if (we_q && is_sd_d && !fault_d) begin
                    mem_WE = 1'b1;
                    mem_WD = wdata_q;
                end
            end
            WRITE: begin
                mem_A  = {addr_q[63:3], 3'b000};
                mem_WE = 1'b1;
                mem_WD = merge_buf_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            merge_buf_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) state_q <= ACCESS;
                end
                ACCESS: begin
                    if (fault_d) begin
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (!we_q) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= load_data_d;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else if (is_sd_d) begin
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                        resp_valid_q <= 1'b1;
                        state_q      <= RESP;
                    end else begin
                        merge_buf_q  <= merge_d;
                        state_q      <= WRITE;
                    end
                end
                WRITE: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed scenarios plus random traffic against a byte-level memory model.
module tb_lsu_mem_master;
    localparam int MW = 1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [2:0]  req_funct3 = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_A;
    logic [63:0] mem_WD;
    logic        mem_WE;
    logic [63:0] mem_ReadData;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] mem [MW];
    logic [7:0]  ref_bytes [8*MW];
    logic        pl_en = 1'b0;
    logic        pl_clr = 1'b0;
    logic [9:0]  pl_idx = '0;
    logic [63:0] pl_val = '0;

    lsu_mem_master #(.MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_ReadData(mem_ReadData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_ReadData = (mem_A[63:3] < 61'(MW)) ? mem[mem_A[12:3]] : '0;

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < MW; i++) mem[i] <= '0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_val;
        end else if (mem_WE && (mem_A[63:3] < 61'(MW))) begin
            mem[mem_A[12:3]] <= mem_WD;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = v | (64'(ref_bytes[idx*8+i]) << (8*i));
        return v;
    endfunction

    // Reference: byte-addressed memory, size = 2**funct3[1:0] bytes
    task automatic ref_do(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                          input logic [2:0] f3, output logic [63:0] rd, output logic err);
        int sz;
        logic [63:0] a;
        logic [63:0] v;
        sz  = 1 << f3[1:0];
        a   = addr;
        rd  = '0;
        err = 1'b0;
        if ((!we && f3 == 3'b111) || (we && f3[2]) || ((addr >> 3) >= 64'(MW))) err = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((addr % 64'(sz)) != 0) err = 1'b1;
`else
        a = addr - (addr % 64'(sz));
`endif
        if (!err) begin
            if (we) begin
                for (int i = 0; i < sz; i++) ref_bytes[int'(a)+i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < sz; i++) v = v | (64'(ref_bytes[int'(a)+i]) << (8*i));
                if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | ({64{1'b1}} << (8*sz));
                rd = v;
            end
        end
    endtask

    task automatic set_word(input int idx, input logic [63:0] val);
        pl_en  = 1'b1;
        pl_idx = 10'(idx);
        pl_val = val;
        @(posedge clk);
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 8; i++) ref_bytes[idx*8+i] = val[8*i +: 8];
    endtask

    // Issues one request (waits for ready, bounded) and observes the following cycles
    task automatic run_txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [2:0] f3, output int resp_cyc, output int we_cyc,
                           output int we_cnt, output logic [63:0] we_addr,
                           output logic [63:0] rdata, output logic err, output int acc_cyc);
        int n;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_funct3 = f3;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        resp_cyc = -1; we_cyc = -1; we_cnt = 0; we_addr = '0; rdata = '0; err = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_WE) begin
                we_cnt++;
                if (we_cyc < 0) begin
                    we_cyc  = k;
                    we_addr = mem_A;
                end
            end
            if (resp_valid) begin
                resp_cyc = k;
                rdata    = resp_rdata;
                err      = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        pl_clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pl_clr = 1'b0;
        for (int i = 0; i < 8*MW; i++) ref_bytes[i] = '0;
        checks++;
        if ({resp_valid, resp_err, resp_rdata} !== 66'd0) begin
            failures++;
            $display("FAIL reset_resp: got v=%0b e=%0b d=%h, want all 0", resp_valid, resp_err, resp_rdata);
        end
        checks++;
        if ({mem_WE, mem_A, mem_WD} !== 129'd0) begin
            failures++;
            $display("FAIL reset_mem: got we=%0b a=%h wd=%h, want all 0", mem_WE, mem_A, mem_WD);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %0b want 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_loads;
        int rc, wc, wn, ac;
        logic [63:0] wa, d, ed;
        logic e, ee;
        logic [63:0] exp_v [3];
        logic [63:0] addrs [3];
        logic [2:0]  f3s [3];
        exp_v[0] = 64'hFFFF_FFFF_FFFF_FF88; addrs[0] = 64'h17; f3s[0] = 3'b000;
        exp_v[1] = 64'h0000_0000_0000_4433; addrs[1] = 64'h12; f3s[1] = 3'b101;
        exp_v[2] = 64'hFFFF_FFFF_8877_6655; addrs[2] = 64'h14; f3s[2] = 3'b010;
        set_word(2, 64'h8877_6655_4433_2211);
        for (int i = 0; i < 3; i++) begin
            ref_do(1'b0, addrs[i], '0, f3s[i], ed, ee);
            run_txn(1'b0, addrs[i], '0, f3s[i], rc, wc, wn, wa, d, e, ac);
            checks++;
            if (d !== exp_v[i] || d !== ed) begin
                failures++;
                $display("FAIL load_data[%0d]: got %h want %h", i, d, exp_v[i]);
            end
            checks++;
            if (rc !== 2 || e !== 1'b0 || wn !== 0) begin
                failures++;
                $display("FAIL load_timing[%0d]: got lat=%0d err=%0b we=%0d want 2/0/0", i, rc, e, wn);
            end
        end
    endtask

    task automatic test_stores;
        int rc, wc, wn, ac;
        logic [63:0] wa, d;
        logic e;
        ref_do(1'b1, 64'h11, 64'hAB, 3'b000, d, e);
        run_txn(1'b1, 64'h11, 64'hAB, 3'b000, rc, wc, wn, wa, d, e, ac);
        checks++;
        if (wn !== 1 || wc !== 2 || rc !== 3) begin
            failures++;
            $display("FAIL sb_timing: got we_cnt=%0d we_cyc=%0d resp=%0d want 1/2/3", wn, wc, rc);
        end
        checks++;
        if (mem[2] !== 64'h8877_6655_4433_AB11 || e !== 1'b0 || d !== 64'd0) begin
            failures++;
            $display("FAIL sb_merge: got word=%h err=%0b d=%h want 887766554433ab11/0/0", mem[2], e, d);
        end
        ref_do(1'b1, 64'h08, 64'h0123_4567_89AB_CDEF, 3'b011, d, e);
        run_txn(1'b1, 64'h08, 64'h0123_4567_89AB_CDEF, 3'b011, rc, wc, wn, wa, d, e, ac);
        checks++;
        if (wn !== 1 || wc !== 1 || wa !== 64'h08 || rc !== 2) begin
            failures++;
            $display("FAIL sd_timing: got we_cnt=%0d we_cyc=%0d a=%h resp=%0d want 1/1/08/2", wn, wc, wa, rc);
        end
        checks++;
        if (mem[1] !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL sd_data: got %h want 0123456789abcdef", mem[1]);
        end
    endtask

    task automatic test_faults;
        int rc, wc, wn, ac;
        logic [63:0] wa, d, ed;
        logic e, ee;
        run_txn(1'b0, 64'(8*MW), '0, 3'b011, rc, wc, wn, wa, d, e, ac);
        checks++;
        if (e !== 1'b1 || d !== 64'd0 || wn !== 0 || rc !== 2) begin
            failures++;
            $display("FAIL ld_oob: got err=%0b d=%h we=%0d lat=%0d want 1/0/0/2", e, d, wn, rc);
        end
        run_txn(1'b1, 64'h20, 64'h55, 3'b100, rc, wc, wn, wa, d, e, ac);
        checks++;
        if (e !== 1'b1 || wn !== 0 || rc !== 2) begin
            failures++;
            $display("FAIL st_bad_f3: got err=%0b we=%0d lat=%0d want 1/0/2", e, wn, rc);
        end
        ref_do(1'b0, 64'h12, '0, 3'b010, ed, ee);
        run_txn(1'b0, 64'h12, '0, 3'b010, rc, wc, wn, wa, d, e, ac);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++;
        if (e !== 1'b1 || d !== 64'd0) begin
            failures++;
            $display("FAIL lw_misalign: got err=%0b d=%h want 1/0", e, d);
        end
`else
        checks++;
        if (e !== 1'b0 || d !== 64'h0000_0000_4433_AB11 || d !== ed) begin
            failures++;
            $display("FAIL lw_misalign: got err=%0b d=%h want 0/000000004433ab11", e, d);
        end
`endif
    endtask

    task automatic test_ignore;
        int n, resp_n, we_n;
        logic [63:0] ed;
        logic ee;
        ref_do(1'b0, 64'h18, '0, 3'b011, ed, ee);
        set_word(4, 64'hCAFE_F00D_1234_5678);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h18; req_funct3 = 3'b011;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b1; req_addr = 64'h20; req_wdata = 64'h1111_2222_3333_4444;
        resp_n = 0; we_n = 0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (resp_valid) begin
                resp_n++;
                checks++;
                if (resp_rdata !== ed) begin
                    failures++;
                    $display("FAIL ignore_data: got %h want %h", resp_rdata, ed);
                end
                req_valid = 1'b0; req_we = 1'b0;
            end
            if (mem_WE) we_n++;
        end
        req_valid = 1'b0; req_we = 1'b0;
        checks++;
        if (resp_n !== 1 || we_n !== 0 || mem[4] !== ref_word(4)) begin
            failures++;
            $display("FAIL ignore_busy: got resp=%0d we=%0d word4=%h want 1/0/%h", resp_n, we_n, mem[4], ref_word(4));
        end
    endtask

    task automatic test_back_to_back;
        int rc, wc, wn, ac;
        logic [63:0] wa, d, ed;
        logic e, ee;
        int acc [4];
        logic        wes [4];
        logic [63:0] ads [4];
        logic [2:0]  fs  [4];
        int          gap [3];
        wes[0] = 1'b0; ads[0] = 64'h30; fs[0] = 3'b011;
        wes[1] = 1'b1; ads[1] = 64'h38; fs[1] = 3'b011;
        wes[2] = 1'b1; ads[2] = 64'h3A; fs[2] = 3'b001;
        wes[3] = 1'b0; ads[3] = 64'h3A; fs[3] = 3'b100;
        gap[0] = 3; gap[1] = 3; gap[2] = 4;
        for (int i = 0; i < 4; i++) begin
            ref_do(wes[i], ads[i], 64'h0000_0000_0000_BEEF + 64'(i), fs[i], ed, ee);
            run_txn(wes[i], ads[i], 64'h0000_0000_0000_BEEF + 64'(i), fs[i], rc, wc, wn, wa, d, e, acc[i]);
            checks++;
            if (d !== ed || e !== ee) begin
                failures++;
                $display("FAIL b2b_data[%0d]: got %h/%0b want %h/%0b", i, d, e, ed, ee);
            end
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc[i+1] - acc[i] !== gap[i]) begin
                failures++;
                $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, acc[i+1] - acc[i], gap[i]);
            end
        end
    endtask

    task automatic test_reset_abort;
        int n, rv;
        set_word(5, 64'h0F0E_0D0C_0B0A_0908);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h28; req_wdata = 64'h7777_6666; req_funct3 = 3'b010;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_WE !== 1'b1) begin
            failures++;
            $display("FAIL abort_write_phase: got mem_WE=%0b want 1", mem_WE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (mem_WE !== 1'b0 || mem_A !== 64'd0 || mem_WD !== 64'd0 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_drop: got we=%0b a=%h wd=%h rv=%0b want all 0", mem_WE, mem_A, mem_WD, resp_valid);
        end
        rv = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (resp_valid) rv++;
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (resp_valid) rv++;
            @(negedge clk);
        end
        checks++;
        if (rv !== 0 || mem[5] !== ref_word(5)) begin
            failures++;
            $display("FAIL abort_effect: got resp=%0d word5=%h want 0/%h", rv, mem[5], ref_word(5));
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: got %0b want 1", req_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int rc, wc, wn, ac, word, elat, ewn;
        logic [63:0] wa, d, ed, addr, wd;
        logic e, ee, we;
        logic [2:0] f3;
        int bad;
        for (int t = 0; t < 200; t++) begin
            word = ($urandom_range(0, 15) == 0) ? MW + int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            addr = 64'(word) * 64'd8 + 64'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            wd   = {$urandom, $urandom};
            ref_do(we, addr, wd, f3, ed, ee);
            elat = (ee || !we || f3[1:0] == 2'b11) ? 2 : 3;
            ewn  = (!ee && we) ? 1 : 0;
            run_txn(we, addr, wd, f3, rc, wc, wn, wa, d, e, ac);
            checks++;
            if (d !== ed || e !== ee || rc !== elat || wn !== ewn) begin
                failures++;
                $display("FAIL rand[%0d] we=%0b a=%h f3=%0d: got d=%h e=%0b lat=%0d wn=%0d want %h/%0b/%0d/%0d",
                         t, we, addr, f3, d, e, rc, wn, ed, ee, elat, ewn);
            end
        end
        bad = 0;
        for (int i = 0; i < 32; i++) if (mem[i] !== ref_word(i)) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL rand_mem: got %0d differing words want 0", bad);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
